alu_op_sequencer: RTL and testbench

//  Sequences ALU_Nbit on behalf of the decode stage. Accepts one ALU request at a time

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer: function codes, FSM states,
// and small op-decode helpers.
package alu_pkg;

  // ALU function select codes
  localparam logic [4:0] FS_CLR  = 5'd0;
  localparam logic [4:0] FS_ADD  = 5'd1;
  localparam logic [4:0] FS_SUB  = 5'd2;
  localparam logic [4:0] FS_DEC  = 5'd3;
  localparam logic [4:0] FS_NEG  = 5'd4;
  localparam logic [4:0] FS_XOR  = 5'd5;
  localparam logic [4:0] FS_ADDC = 5'd6;
  localparam logic [4:0] FS_INC  = 5'd7;
  localparam logic [4:0] FS_SET  = 5'd8;
  localparam logic [4:0] FS_NOT  = 5'd9;
  localparam logic [4:0] FS_AND  = 5'd10;
  localparam logic [4:0] FS_OR   = 5'd11;
  localparam logic [4:0] FS_MOVA = 5'd12;
  localparam logic [4:0] FS_SHR  = 5'd13;
  localparam logic [4:0] FS_SHL  = 5'd14;
  localparam logic [4:0] FS_ASHR = 5'd15;
  localparam logic [4:0] FS_MOVB = 5'd16;

  // First code that the ALU does not implement; everything at or above is illegal
  localparam logic [4:0] FS_ILLEGAL_MIN = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } alu_state_t;

  // Single-bit shift ops that get expanded into repeated ALU passes
  function automatic logic is_shift(input logic [4:0] op);
    return (op == FS_SHR) || (op == FS_SHL) || (op == FS_ASHR);
  endfunction

  // Arithmetic ops whose carry-out is architecturally visible
  function automatic logic writes_carry(input logic [4:0] op);
    return (op == FS_ADD) || (op == FS_SUB) || (op == FS_DEC) ||
           (op == FS_NEG) || (op == FS_ADDC) || (op == FS_INC);
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return op >= FS_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences an external ALU for the decode stage: one request at a time,
// owns the architectural carry, expands multi-bit shifts into single-bit
// ALU passes, and returns the result.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Once valid is raised its payload is held until that edge;
// ready may be raised or dropped freely and carries no obligation by itself.
import alu_pkg::*;

module alu_op_sequencer #(
  parameter int N       = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_op,
  input  logic [N-1:0]       req_a,
  input  logic [N-1:0]       req_b,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic               carry_clr,
  output logic [4:0]         alu_fs,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic               alu_cin,
  input  logic [N-1:0]       alu_fout,
  input  logic [3:0]         alu_status,
  input  logic               alu_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_data,
  output logic [3:0]         rsp_status,
  output logic               rsp_err,
  output logic               carry_q,
  output logic               busy,
  output alu_state_t         state_dbg
);

  alu_state_t         state;
  alu_state_t         state_nxt;
  logic [4:0]         op_q;
  logic [N-1:0]       a_q;     // operand A, and the running accumulator while shifting
  logic [N-1:0]       b_q;
  logic [SHAMT_W-1:0] cnt_q;   // remaining single-bit shift passes

  logic accept;
  logic shift_zero;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign shift_zero = is_shift(req_op) && (req_shamt == '0);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and ALU / handshake output drive
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_fs    = FS_CLR;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_illegal(req_op))                             state_nxt = ST_DONE;
          else if (is_shift(req_op) && (req_shamt != '0))     state_nxt = ST_SHIFT;
          else                                                state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_fs    = op_q;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_cin   = (op_q == FS_ADDC) ? carry_q : 1'b0;
        state_nxt = ST_DONE;
      end
      ST_SHIFT: begin
        alu_fs = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
        if (cnt_q == SHAMT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, shift accumulator/counter and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= FS_CLR;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // A zero-place shift is just a pass-through of A
            op_q  <= shift_zero ? FS_MOVA : req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            cnt_q <= req_shamt;
            if (is_illegal(req_op)) begin
              rsp_err    <= 1'b1;
              rsp_data   <= '0;
              rsp_status <= '0;
            end else begin
              rsp_err <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          rsp_data   <= alu_fout;
          rsp_status <= alu_status;
        end
        ST_SHIFT: begin
          a_q   <= alu_fout;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            rsp_data   <= alu_fout;
            rsp_status <= alu_status;
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural carry: written only by arithmetic ops in EXEC; clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      carry_q <= 1'b0;
    else if (carry_clr)                             carry_q <= 1'b0;
    else if ((state == ST_EXEC) && writes_carry(op_q)) carry_q <= alu_cout;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, directed requests, and a
// scoreboard monitor that checks every response against an expected queue.
import alu_pkg::*;

module tb_alu_op_sequencer;

  localparam int N       = 16;
  localparam int SHAMT_W = 4;
  localparam int W       = N + 5;   // {err, status[3:0], data[N-1:0]}

  logic               clk;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [4:0]         req_op;
  logic [N-1:0]       req_a;
  logic [N-1:0]       req_b;
  logic [SHAMT_W-1:0] req_shamt;
  logic               carry_clr;
  logic [4:0]         alu_fs;
  logic [N-1:0]       alu_a;
  logic [N-1:0]       alu_b;
  logic               alu_cin;
  logic [N-1:0]       alu_fout;
  logic [3:0]         alu_status;
  logic               alu_cout;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [N-1:0]       rsp_data;
  logic [3:0]         rsp_status;
  logic               rsp_err;
  logic               carry_q;
  logic               busy;
  alu_state_t         state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  alu_op_sequencer #(.N(N), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .carry_clr(carry_clr),
    .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_fout(alu_fout), .alu_status(alu_status), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_err(rsp_err), .carry_q(carry_q),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- behavioural ALU ----------------
  logic [N:0]   alu_s;
  logic [N-1:0] alu_f;
  logic         alu_v;
  logic         alu_c;
  always_comb begin
    alu_s = '0;
    alu_f = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    case (alu_fs)
      FS_ADD, FS_ADDC: begin
        alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
        alu_f = alu_s[N-1:0];
        alu_c = alu_s[N];
        alu_v = (alu_a[N-1] == alu_b[N-1]) && (alu_f[N-1] != alu_a[N-1]);
      end
      FS_SUB: begin
        alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
        alu_f = alu_s[N-1:0];
        alu_c = alu_s[N];
        alu_v = (alu_a[N-1] != alu_b[N-1]) && (alu_f[N-1] != alu_a[N-1]);
      end
      FS_DEC: begin
        alu_s = {1'b0, alu_a} + {1'b0, {N{1'b1}}};
        alu_f = alu_s[N-1:0];
        alu_c = alu_s[N];
        alu_v = alu_a[N-1] && !alu_f[N-1];
      end
      FS_NEG: begin
        alu_s = {1'b0, ~alu_a} + {{N{1'b0}}, 1'b1};
        alu_f = alu_s[N-1:0];
        alu_c = alu_s[N];
        alu_v = (alu_a == {1'b1, {(N-1){1'b0}}});
      end
      FS_INC: begin
        alu_s = {1'b0, alu_a} + {{N{1'b0}}, 1'b1};
        alu_f = alu_s[N-1:0];
        alu_c = alu_s[N];
        alu_v = !alu_a[N-1] && alu_f[N-1];
      end
      FS_XOR:  alu_f = alu_a ^ alu_b;
      FS_SET:  alu_f = {N{1'b1}};
      FS_NOT:  alu_f = ~alu_a;
      FS_AND:  alu_f = alu_a & alu_b;
      FS_OR:   alu_f = alu_a | alu_b;
      FS_MOVA: alu_f = alu_a;
      FS_SHR:  alu_f = alu_a >> 1;
      FS_SHL:  alu_f = alu_a << 1;
      FS_ASHR: alu_f = {alu_a[N-1], alu_a[N-1:1]};
      FS_MOVB: alu_f = alu_b;
      default: alu_f = '0;
    endcase
  end
  assign alu_fout   = alu_f;
  assign alu_cout   = alu_c;
  assign alu_status = {alu_v, alu_c, alu_f[N-1], (alu_f == '0)};

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data 0x%0h expected no response at %0t", rsp_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data",   {16'd0, rsp_data},   {16'd0, mon_e[N-1:0]});
        check("rsp_status", {28'd0, rsp_status}, {28'd0, mon_e[N+3:N]});
        check("rsp_err",    {31'd0, rsp_err},    {31'd0, mon_e[N+4]});
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request, checks the ALU drive in the first post-accept cycle and
  // the accept-to-rsp_valid latency; optionally waits for the handshake and
  // checks the carry register afterwards.
  task automatic send(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [SHAMT_W-1:0] sh, input logic [N-1:0] ed,
                      input logic [3:0] es, input logic ee, input int elat,
                      input logic [4:0] efs, input logic ecin, input logic ecarry,
                      input logic clr_exec, input logic wait_done);
    int n;
    exp_q.push_back({ee, es, ed});
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_shamt = sh;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      void'(exp_q.pop_back());
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    carry_clr = clr_exec;
    @(negedge clk);
    check("alu_fs",  {27'd0, alu_fs},  {27'd0, efs});
    check("alu_cin", {31'd0, alu_cin}, {31'd0, ecin});
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      carry_clr = 1'b0;
      @(negedge clk);
      n++;
    end
    carry_clr = 1'b0;
    check("latency", n, elat);
    if (wait_done) begin
      n = 0;
      while (busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("idle_after_rsp", {31'd0, busy}, 32'd0);
      check("carry_q", {31'd0, carry_q}, {31'd0, ecarry});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = FS_CLR;
    req_a     = '0;
    req_b     = '0;
    req_shamt = '0;
    carry_clr = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_alu_fs",    {27'd0, alu_fs},    {27'd0, FS_CLR});
    check("rst_carry_q",   {31'd0, carry_q},   32'd0);
    check("rst_rsp_data",  {16'd0, rsp_data},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //    op       a         b         sh     data      status  err lat fs       cin   carry clr  wait
    send(FS_ADD,  16'h7FFF, 16'h0001, 4'd0,  16'h8000, 4'b1010, 0,  1, FS_ADD,  1'b0, 1'b0, 1'b0, 1'b1);
    send(FS_ADD,  16'hFFFF, 16'h0001, 4'd0,  16'h0000, 4'b0101, 0,  1, FS_ADD,  1'b0, 1'b1, 1'b0, 1'b1);
    send(FS_ADDC, 16'h0001, 16'h0002, 4'd0,  16'h0004, 4'b0000, 0,  1, FS_ADDC, 1'b1, 1'b0, 1'b0, 1'b1);
    send(FS_SUB,  16'h0005, 16'h0003, 4'd0,  16'h0002, 4'b0100, 0,  1, FS_SUB,  1'b0, 1'b1, 1'b0, 1'b1);
    send(5'd20,   16'h1234, 16'h5678, 4'd3,  16'h0000, 4'b0000, 1,  0, FS_CLR,  1'b0, 1'b1, 1'b0, 1'b1);
    send(FS_AND,  16'hF0F0, 16'h3C3C, 4'd0,  16'h3030, 4'b0000, 0,  1, FS_AND,  1'b0, 1'b1, 1'b0, 1'b1);
    send(FS_SHL,  16'h0123, 16'h0000, 4'd4,  16'h1230, 4'b0000, 0,  4, FS_SHL,  1'b0, 1'b1, 1'b0, 1'b1);
    send(FS_ASHR, 16'h8000, 16'h0000, 4'd3,  16'hF000, 4'b0010, 0,  3, FS_ASHR, 1'b0, 1'b1, 1'b0, 1'b1);
    send(FS_SHR,  16'h0123, 16'h0000, 4'd0,  16'h0123, 4'b0000, 0,  1, FS_MOVA, 1'b0, 1'b1, 1'b0, 1'b1);
    send(FS_SHR,  16'h8000, 16'h0000, 4'd15, 16'h0001, 4'b0000, 0, 15, FS_SHR,  1'b0, 1'b1, 1'b0, 1'b1);
    // carry_clr coincident with a carry-writing EXEC: clear wins
    send(FS_SUB,  16'h0005, 16'h0003, 4'd0,  16'h0002, 4'b0100, 0,  1, FS_SUB,  1'b0, 1'b0, 1'b1, 1'b1);
    send(FS_SUB,  16'h0007, 16'h0007, 4'd0,  16'h0000, 4'b0101, 0,  1, FS_SUB,  1'b0, 1'b1, 1'b0, 1'b1);

    // carry_clr while idle
    @(posedge clk); #1;
    carry_clr = 1'b1;
    @(posedge clk); #1;
    carry_clr = 1'b0;
    @(negedge clk);
    check("carry_clr_idle", {31'd0, carry_q}, 32'd0);
    send(FS_SUB,  16'h0005, 16'h0003, 4'd0,  16'h0002, 4'b0100, 0,  1, FS_SUB,  1'b0, 1'b1, 1'b0, 1'b1);

    // Back-pressure: response held while rsp_ready is low and a request waits
    rsp_ready = 1'b0;
    send(FS_XOR,  16'h00FF, 16'h0F0F, 4'd0,  16'h0FF0, 4'b0000, 0,  1, FS_XOR,  1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 4'b0010, 16'hBEEF});
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = FS_MOVB;
    req_a     = 16'h1111;
    req_b     = 16'hBEEF;
    req_shamt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_rsp_data",  {16'd0, rsp_data},  32'h0FF0);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("movb_accepted_fs", {27'd0, alu_fs}, {27'd0, FS_MOVB});
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("movb_carry_q", {31'd0, carry_q}, 32'd1);

    // Reset pulsed during SHIFT with two passes left
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = FS_SHL;
    req_a     = 16'h0001;
    req_b     = 16'h0000;
    req_shamt = 4'd5;
    @(negedge clk);
    check("rst_test_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_test_in_shift", {30'd0, state_dbg}, {30'd0, ST_SHIFT});
    reset = 1'b1;
    #1;
    check("abort_state",     {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_carry_q",   {31'd0, carry_q},   32'd0);
    check("abort_alu_fs",    {27'd0, alu_fs},    {27'd0, FS_CLR});
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Alive after the abort
    send(FS_ADD,  16'h0001, 16'h0002, 4'd0,  16'h0003, 4'b0000, 0,  1, FS_ADD,  1'b0, 1'b0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
